i2s_master_clk_seq: RTL and testbench

- Master-mode timing sequencer for the I2S transceiver.
- Generates the serial clock (sck_o) and word select (ws_o) from the system clock.
- Issues single-cycle strobes that sequence the Tx shifter (tx_shift), the Rx sampler (rx_sample) and the Tx FIFO pop (word_load).
- Enabled when OP.mode is MR or MT. Slave modes keep this block disabled.

---
 rtl/ctrl_pkg.sv | 6 +
 rtl/i2s_master_clk_seq.sv | 157 +++++++++++++++
 tb/tb_i2s_master_clk_seq.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared control-register field types for the I2S transceiver.
package ctrl_pkg;
  typedef enum logic { f16bits = 1'b0, f32bits = 1'b1 } frame_size_t;
  typedef enum logic [1:0] { I2S = 2'd0, MSB = 2'd1, LSB = 2'd2 } standard_t;
  typedef enum logic { LEFT = 1'b0, RIGHT = 1'b1 } channel_t;
endpackage

// File: rtl/i2s_master_clk_seq.sv
// Master-mode I2S timing sequencer: divides clk into sck, drives ws and
// issues single-cycle strobes for the Tx shifter, Rx sampler and Tx FIFO pop.
module i2s_master_clk_seq #(
  parameter int unsigned DIV_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   stop,
  input  logic                   stereo,
  input  ctrl_pkg::frame_size_t  frame_size,
  input  ctrl_pkg::standard_t    standard,
  input  logic [DIV_W-1:0]       sck_div,
  output logic                   sck_o,
  output logic                   ws_o,
  output logic                   tx_shift,
  output logic                   rx_sample,
  output logic                   word_load,
  output ctrl_pkg::channel_t     load_ch,
  output logic [4:0]             bit_idx,
  output logic                   idle_o
);
  import ctrl_pkg::*;

  typedef enum logic [1:0] { IDLE, RUN, DRAIN } state_t;

  state_t           state, state_n;
  logic [DIV_W-1:0] div_cnt, div_n;
  channel_t         ch, ch_n, lch_n;
  logic             sck_n, ws_n, tx_n, rx_n, wl_n, idle_n;
  logic [4:0]       bit_n, last;

  frame_size_t      fs_s, fs_n;
  standard_t        std_s, std_n;
  logic             stereo_s, stereo_n;
  logic [DIV_W-1:0] div_s, divs_n;

  always_comb begin
    state_n  = state;
    div_n    = div_cnt;
    ch_n     = ch;
    lch_n    = load_ch;
    sck_n    = sck_o;
    ws_n     = ws_o;
    bit_n    = bit_idx;
    tx_n     = 1'b0;
    rx_n     = 1'b0;
    wl_n     = 1'b0;
    fs_n     = fs_s;
    std_n    = std_s;
    stereo_n = stereo_s;
    divs_n   = div_s;
    last     = (fs_s == f32bits) ? 5'd31 : 5'd15;

    if (state == IDLE) begin
      if (en && !stop) begin
        state_n  = RUN;
        fs_n     = frame_size;
        std_n    = standard;
        stereo_n = stereo;
        divs_n   = sck_div;
        sck_n    = 1'b0;
        div_n    = '0;
        bit_n    = '0;
        ch_n     = LEFT;
        ws_n     = 1'b0;
        tx_n     = 1'b1;
        wl_n     = 1'b1;
        lch_n    = LEFT;
      end
    end else if (!en) begin
      state_n = IDLE;
      sck_n   = 1'b0;
      div_n   = '0;
      bit_n   = '0;
      ch_n    = LEFT;
      ws_n    = 1'b0;
      lch_n   = LEFT;
    end else begin
      if (state == RUN && stop)
        state_n = DRAIN;
      if (div_cnt == div_s) begin
        div_n = '0;
        sck_n = ~sck_o;
        if (!sck_o) begin
          rx_n = 1'b1;
        end else begin
          tx_n = 1'b1;
          if (bit_idx == last) begin
            bit_n = '0;
            ch_n  = (ch == LEFT) ? RIGHT : LEFT;
            // A drain ends on the falling edge that would open the next LEFT slot.
            if (ch_n == LEFT && state == DRAIN) begin
              state_n = IDLE;
              sck_n   = 1'b0;
              ws_n    = 1'b0;
              tx_n    = 1'b0;
              lch_n   = LEFT;
            end else begin
              wl_n = stereo_s || (ch_n == LEFT);
              if (wl_n)
                lch_n = ch_n;
              if (std_s != I2S)
                ws_n = (ch_n == RIGHT);
            end
          end else begin
            bit_n = bit_idx + 5'd1;
            // I2S leads the slot change by one sck.
            if (std_s == I2S && bit_n == last)
              ws_n = (ch == LEFT);
          end
        end
      end else begin
        div_n = div_cnt + 1'b1;
      end
    end

    idle_n = (state_n == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      div_cnt   <= '0;
      ch        <= LEFT;
      sck_o     <= 1'b0;
      ws_o      <= 1'b0;
      tx_shift  <= 1'b0;
      rx_sample <= 1'b0;
      word_load <= 1'b0;
      load_ch   <= LEFT;
      bit_idx   <= '0;
      idle_o    <= 1'b1;
      fs_s      <= f16bits;
      std_s     <= I2S;
      stereo_s  <= 1'b0;
      div_s     <= '0;
    end else begin
      state     <= state_n;
      div_cnt   <= div_n;
      ch        <= ch_n;
      sck_o     <= sck_n;
      ws_o      <= ws_n;
      tx_shift  <= tx_n;
      rx_sample <= rx_n;
      word_load <= wl_n;
      load_ch   <= lch_n;
      bit_idx   <= bit_n;
      idle_o    <= idle_n;
      fs_s      <= fs_n;
      std_s     <= std_n;
      stereo_s  <= stereo_n;
      div_s     <= divs_n;
    end
  end

endmodule

// File: tb/tb_i2s_master_clk_seq.sv
// Bench for i2s_master_clk_seq: frame-position reference model plus directed
// timing pins and randomized enable/stop/reset traffic.
module tb_i2s_master_clk_seq;
  import ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst, en, stop, stereo;
  frame_size_t frame_size;
  standard_t   standard;
  logic [7:0]  sck_div;
  logic        sck_o, ws_o, tx_shift, rx_sample, word_load, idle_o;
  channel_t    load_ch;
  logic [4:0]  bit_idx;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  i2s_master_clk_seq #(.DIV_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .stop(stop), .stereo(stereo),
    .frame_size(frame_size), .standard(standard), .sck_div(sck_div),
    .sck_o(sck_o), .ws_o(ws_o), .tx_shift(tx_shift), .rx_sample(rx_sample),
    .word_load(word_load), .load_ch(load_ch), .bit_idx(bit_idx), .idle_o(idle_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: a run is described only by the cycle count m_t since its
  // first cycle; every output follows from m_t by division against the period.
  bit          m_run = 1'b0, m_drain = 1'b0, m_i2s = 1'b0, m_stereo = 1'b0;
  int unsigned m_t = 0, m_end = 0, m_h = 1, m_n = 16;

  always @(posedge clk) begin
    if (rst) begin
      m_run = 1'b0;
    end else if (!m_run) begin
      if (en && !stop) begin
        m_run    = 1'b1;
        m_drain  = 1'b0;
        m_t      = 0;
        m_h      = int'(sck_div) + 1;
        m_n      = (frame_size == f32bits) ? 32 : 16;
        m_i2s    = (standard == I2S);
        m_stereo = stereo;
      end
    end else if (!en) begin
      m_run = 1'b0;
    end else begin
      if (stop && !m_drain) begin
        m_drain = 1'b1;
        m_end   = ((m_t + 1) / (4 * m_h * m_n) + 1) * (4 * m_h * m_n);
      end
      m_t++;
      if (m_drain && m_t == m_end)
        m_run = 1'b0;
    end
  end

  always @(negedge clk) begin
    int unsigned ph, k, s;
    logic        e_sck, e_ws, e_tx, e_rx, e_wl, e_idle;
    logic [4:0]  e_bit;
    channel_t    e_ch;
    if (chk_on) begin
      if (!m_run) begin
        {e_sck, e_ws, e_tx, e_rx, e_wl} = '0;
        e_bit  = '0;
        e_idle = 1'b1;
        e_ch   = LEFT;
      end else begin
        ph     = m_t % (2 * m_h);
        k      = m_t / (2 * m_h);
        s      = k / m_n;
        e_sck  = ((m_t / m_h) % 2) == 1;
        e_rx   = (ph == m_h);
        e_tx   = (ph == 0);
        e_bit  = 5'(k % m_n);
        e_wl   = (ph == 0) && (k % m_n == 0) && (m_stereo || (s % 2 == 0));
        e_ch   = ((s % 2) == 1) ? RIGHT : LEFT;
        e_ws   = m_i2s ? ((((k + 1) / m_n) % 2) == 1) : ((s % 2) == 1);
        e_idle = 1'b0;
      end
      check("sck_o", sck_o, e_sck);
      check("ws_o", ws_o, e_ws);
      check("tx_shift", tx_shift, e_tx);
      check("rx_sample", rx_sample, e_rx);
      check("word_load", word_load, e_wl);
      check("bit_idx", bit_idx, e_bit);
      check("idle_o", idle_o, e_idle);
      if (e_wl)
        check("load_ch", load_ch, e_ch);
    end
  end

  int wl_t[$];
  int wl_c[$];
  int ws_t[$];
  int n_tx, n_rx;

  function automatic int qat(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  // First negedge seen here is cycle 0 of a run started by the caller.
  task automatic observe(input int n, input int win);
    logic pws;
    pws = 1'b0;
    wl_t.delete(); wl_c.delete(); ws_t.delete();
    n_tx = 0; n_rx = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (word_load) begin
        wl_t.push_back(c);
        wl_c.push_back(int'(load_ch));
      end
      if (c > 0 && ws_o !== pws) ws_t.push_back(c);
      pws = ws_o;
      if (c < win) begin
        if (tx_shift) n_tx++;
        if (rx_sample) n_rx++;
      end
    end
  endtask

  task automatic config_run(input frame_size_t fs, input standard_t sd, input logic st, input logic [7:0] dv);
    frame_size = fs; standard = sd; stereo = st; sck_div = dv;
    stop = 1'b0; en = 1'b1;
  endtask

  task automatic stop_all();
    en = 1'b0; stop = 1'b0; rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; en = 1'b0; stop = 1'b0; stereo = 1'b1;
    frame_size = f16bits; standard = MSB; sck_div = 8'd1;
    repeat (2) @(negedge clk);
    chk_on = 1'b1;
    check("reset_idle", idle_o, 1);
    check("reset_sck", sck_o, 0);
    check("reset_ws", ws_o, 0);
    check("reset_wl", word_load, 0);
    check("reset_load_ch", load_ch, LEFT);
    rst = 1'b0;
    @(negedge clk);

    // MSB, 16-bit stereo, sck period 4
    config_run(f16bits, MSB, 1'b1, 8'd1);
    observe(192, 64);
    check("msb_wl_count", wl_t.size(), 3);
    check("msb_wl0", qat(wl_t, 0), 0);
    check("msb_wl1", qat(wl_t, 1), 64);
    check("msb_wl2", qat(wl_t, 2), 128);
    check("msb_ch1", qat(wl_c, 1), 1);
    check("msb_ch2", qat(wl_c, 2), 0);
    check("msb_ws0", qat(ws_t, 0), 64);
    check("msb_ws1", qat(ws_t, 1), 128);
    check("msb_tx_per_slot", n_tx, 16);
    check("msb_rx_per_slot", n_rx, 16);
    stop_all();

    // I2S: ws leads word_load by one sck
    config_run(f16bits, I2S, 1'b1, 8'd1);
    observe(192, 64);
    check("i2s_ws0", qat(ws_t, 0), 60);
    check("i2s_ws1", qat(ws_t, 1), 124);
    check("i2s_wl1", qat(wl_t, 1), 64);
    check("i2s_wl2", qat(wl_t, 2), 128);
    stop_all();

    // 32-bit mono, sck_div=0
    config_run(f32bits, LSB, 1'b0, 8'd0);
    observe(300, 0);
    check("mono_wl_count", wl_t.size(), 3);
    check("mono_wl1", qat(wl_t, 1), 128);
    check("mono_wl2", qat(wl_t, 2), 256);
    check("mono_ch1", qat(wl_c, 1), 0);
    check("mono_ws_count", ws_t.size(), 4);
    check("mono_ws0", qat(ws_t, 0), 64);
    stop_all();

    // Graceful stop at bit_idx 5 of LEFT
    config_run(f16bits, MSB, 1'b1, 8'd1);
    observe(21, 0);
    check("stop_at_bit5", bit_idx, 5);
    stop = 1'b1;
    begin
      int wl_seen;
      wl_seen = 0;
      for (int c = 21; c <= 129; c++) begin
        @(negedge clk);
        stop = 1'b0;
        if (c <= 128 && word_load) wl_seen++;
        if (c == 127) check("stop_busy_127", idle_o, 0);
        if (c == 128) begin
          check("stop_idle_128", idle_o, 1);
          check("stop_sck_128", sck_o, 0);
          check("stop_ws_128", ws_o, 0);
        end
        if (c == 129) check("stop_restart_wl", word_load, 1);
      end
      check("stop_wl_in_drain", wl_seen, 1);
    end
    stop_all();

    // Abort mid-slot, then re-enable
    config_run(f16bits, I2S, 1'b1, 8'd2);
    observe(37, 0);
    en = 1'b0;
    @(negedge clk);
    check("abort_idle", idle_o, 1);
    check("abort_sck", sck_o, 0);
    check("abort_bit", bit_idx, 0);
    en = 1'b1;
    @(negedge clk);
    check("reen_wl", word_load, 1);
    check("reen_ch", load_ch, LEFT);
    stop_all();

    // Reset mid-run with new divider
    config_run(f16bits, MSB, 1'b1, 8'd1);
    observe(30, 0);
    rst = 1'b1; sck_div = 8'd3;
    @(negedge clk);
    check("rst_mid_idle", idle_o, 1);
    check("rst_mid_sck", sck_o, 0);
    check("rst_mid_tx", tx_shift, 0);
    rst = 1'b0;
    observe(64, 32);
    check("rst_new_wl0", qat(wl_t, 0), 0);
    check("rst_new_tx", n_tx, 4);
    check("rst_new_rx", n_rx, 4);
    stop_all();

    // Divider change without reset is ignored
    config_run(f16bits, MSB, 1'b1, 8'd1);
    observe(10, 0);
    sck_div = 8'd3;
    observe(64, 64);
    check("hold_div_tx", n_tx, 16);
    check("hold_div_rx", n_rx, 16);
    stop_all();

    // Randomized traffic
    for (int it = 0; it < 12; it++) begin
      config_run($urandom_range(0, 1) ? f32bits : f16bits, standard_t'($urandom_range(0, 2)),
                 1'($urandom_range(0, 1)), 8'($urandom_range(0, 3)));
      for (int c = 0; c < 600; c++) begin
        int unsigned r;
        @(negedge clk);
        r    = $urandom_range(0, 999);
        stop = (r < 4);
        en   = !(r >= 4 && r < 7);
        rst  = (r == 7);
        if (r % 50 == 9) begin
          frame_size = $urandom_range(0, 1) ? f32bits : f16bits;
          standard   = standard_t'($urandom_range(0, 2));
          stereo     = 1'($urandom_range(0, 1));
          sck_div    = 8'($urandom_range(0, 3));
        end
      end
      stop_all();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
